r_burst_arbiter: RTL

//  - Shares the single R-beat input of the outgoing response buffer between NUM_SRC internal response sources.
//  - Round-robin grant at burst granularity; grant locked until the LAST beat is accepted, so bursts never interleave.
//  - Sits between the ordering unit's per-source response queues and the response buffer's r_if receiver port.
//  - Counts beats per burst and flags sources that overrun MAX_BEATS.

---
 rtl/rob_pkg.sv | 17 +
 rtl/r_if.sv | 15 +
 rtl/r_burst_arbiter_rr_pick.sv | 27 ++
 rtl/r_burst_arbiter.sv | 121 ++++++++++++
 4 files changed

// File: rtl/rob_pkg.sv
// Shared types and constants for the response ordering block.
package rob_pkg;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Width of a counter that must hold 0..max_beats inclusive.
    function automatic int nbeats_w(input int max_beats);
        return $clog2(max_beats + 1);
    endfunction

endpackage

// File: rtl/r_if.sv
// R-channel beat interface between the arbiter and the response buffer.
interface r_if #(
    parameter int ID_WIDTH   = 4,
    parameter int DATA_WIDTH = 64
);
    logic                  valid;
    logic                  ready;
    logic [ID_WIDTH-1:0]   id;
    logic [DATA_WIDTH-1:0] data;
    logic [1:0]            resp;
    logic                  last;

    modport sender   (output valid, id, data, resp, last, input  ready);
    modport receiver (input  valid, id, data, resp, last, output ready);
endinterface

// File: rtl/r_burst_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request strictly after ptr, wrapping.
module rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic                 any,
    output logic [$clog2(N)-1:0] idx
);
    localparam int IW = $clog2(N);

    logic [IW-1:0] cand;

    // Walk N candidates starting at ptr+1; wrap is explicit so N need not be a power of 2.
    always_comb begin
        any  = 1'b0;
        idx  = '0;
        cand = ptr;
        for (int k = 0; k < N; k++) begin
            cand = (cand == IW'(N - 1)) ? '0 : cand + IW'(1);
            if (!any && req[cand]) begin
                any = 1'b1;
                idx = cand;
            end
        end
    end
endmodule

// File: rtl/r_burst_arbiter.sv
// Burst-granular round-robin arbiter merging NUM_SRC R-beat sources onto one r_if.
module r_burst_arbiter
    import rob_pkg::*;
#(
    parameter int NUM_SRC    = 4,
    parameter int ID_WIDTH   = 4,
    parameter int DATA_WIDTH = 64,
    parameter int MAX_BEATS  = 32
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_SRC-1:0]             src_valid,
    output logic [NUM_SRC-1:0]             src_ready,
    input  logic [NUM_SRC*ID_WIDTH-1:0]    src_id,
    input  logic [NUM_SRC*DATA_WIDTH-1:0]  src_data,
    input  logic [NUM_SRC*2-1:0]           src_resp,
    input  logic [NUM_SRC-1:0]             src_last,
    r_if.sender                            out_r,
    output logic [$clog2(NUM_SRC)-1:0]     gnt_idx,
    output logic                           busy,
    output logic [NUM_SRC-1:0]             err_overrun
);
    localparam int SW = $clog2(NUM_SRC);
    localparam int CW = nbeats_w(MAX_BEATS);

    arb_state_e         state_q, state_d;
    logic [SW-1:0]      rr_ptr_q, rr_ptr_d;
    logic [SW-1:0]      gnt_idx_q, gnt_idx_d;
    logic [CW-1:0]      beat_cnt_q, beat_cnt_d;
    logic [NUM_SRC-1:0] err_q, err_d;

    logic               pick_any;
    logic [SW-1:0]      pick_idx;
    logic               locked;
    logic               hs;

    rr_pick #(.N(NUM_SRC)) u_pick (
        .req (src_valid),
        .ptr (rr_ptr_q),
        .any (pick_any),
        .idx (pick_idx)
    );

    assign locked = (state_q == ARB_LOCKED);

    // Forward the locked source's beat; everything idles at zero otherwise.
    always_comb begin
        out_r.valid = 1'b0;
        out_r.id    = '0;
        out_r.data  = '0;
        out_r.resp  = '0;
        out_r.last  = 1'b0;
        src_ready   = '0;
        if (locked) begin
            out_r.valid          = src_valid[gnt_idx_q];
            out_r.id             = src_id[gnt_idx_q*ID_WIDTH +: ID_WIDTH];
            out_r.data           = src_data[gnt_idx_q*DATA_WIDTH +: DATA_WIDTH];
            out_r.resp           = src_resp[gnt_idx_q*2 +: 2];
            out_r.last           = src_last[gnt_idx_q];
            src_ready[gnt_idx_q] = out_r.ready;
        end
    end

    assign hs = out_r.valid & out_r.ready;

    // Next-state: arbitrate in IDLE, count beats and release on LAST while LOCKED.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        gnt_idx_d  = gnt_idx_q;
        beat_cnt_d = beat_cnt_q;
        err_d      = err_q;
        case (state_q)
            ARB_IDLE: begin
                if (pick_any) begin
                    gnt_idx_d  = pick_idx;
                    beat_cnt_d = '0;
                    state_d    = ARB_LOCKED;
                end
            end
            ARB_LOCKED: begin
                if (hs) begin
                    if (out_r.last) begin
                        state_d    = ARB_IDLE;
                        rr_ptr_d   = gnt_idx_q;
                        beat_cnt_d = '0;
                    end else begin
                        // The MAX_BEATS-th beat without LAST is already one too many.
                        if (beat_cnt_q == CW'(MAX_BEATS - 1))
                            err_d[gnt_idx_q] = 1'b1;
                        if (beat_cnt_q != CW'(MAX_BEATS))
                            beat_cnt_d = beat_cnt_q + CW'(1);
                    end
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // State registers; reset forgets any partial burst.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ARB_IDLE;
            rr_ptr_q   <= SW'(NUM_SRC - 1);
            gnt_idx_q  <= '0;
            beat_cnt_q <= '0;
            err_q      <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            gnt_idx_q  <= gnt_idx_d;
            beat_cnt_q <= beat_cnt_d;
            err_q      <= err_d;
        end
    end

    assign gnt_idx     = gnt_idx_q;
    assign busy        = locked;
    assign err_overrun = err_q;

endmodule
